// File: rtl/dist_ram_sdp.sv
// Simple-dual-port distributed RAM: sync write, async or registered read,
// with an optional post-reset clear sweep that refills every word.
module dist_ram_sdp #(
  parameter int WIDTH = 4,
  parameter int ADDR_WIDTH = 5,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter bit READ_REG = 1'b0,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [WIDTH-1:0]      D,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [WIDTH-1:0]      O,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam bit WF = (WRITE_MODE == "WRITE_FIRST");

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state_q = IDLE;
  state_t state_d;
  logic [ADDR_WIDTH:0] cnt_q = '0;
  logic [ADDR_WIDTH:0] cnt_d;
  logic busy_q = 1'b0;
  logic busy_d;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  logic clr_wr;
  logic usr_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (RST) begin
      cnt_d = '0;
      if (CLEAR_ON_RESET) begin
        state_d = CLEAR;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        CLEAR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge WCLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    busy_q  <= busy_d;
  end

  // Sweep owns the write port; user writes wait for it to finish.
  assign clr_wr = (state_q == CLEAR) && !RST;
  assign usr_wr = WE && !RST && !busy_q;

  always_ff @(posedge WCLK) begin
    if (clr_wr)
      mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    else if (usr_wr)
      mem[WADDR] <= D;
  end

  generate
    if (READ_REG) begin : g_reg
      logic [WIDTH-1:0] o_q = '0;
      always_ff @(posedge WCLK) begin
        if (RST || busy_q)
          o_q <= '0;
        else if (WF && WE && (WADDR == RADDR))
          o_q <= D;
        else
          o_q <= mem[RADDR];
      end
      assign O = o_q;
    end else begin : g_async
      assign O = mem[RADDR];
    end
  endgenerate

  assign BUSY = busy_q;

endmodule
